// File: rtl/dmem_stage.sv
// MEM stage: owns the data RAM, performs byte/half/word loads and stores with
// extension and misalign detection, registers MEM/WB, and zero-sweeps the RAM after reset.
//
// state   | meaning
// S_CLEAR | sweeping zeros into every word, instructions refused
// S_RUN   | accepting one instruction per cycle
module dmem_stage #(
  parameter int DEPTH_LOG2 = 8
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        in_valid,
  output logic        in_ready,
  input  logic        mem_read,
  input  logic        mem_write,
  input  logic        mem_to_reg,
  input  logic [1:0]  size,
  input  logic        load_unsigned,
  input  logic [31:0] addr,
  input  logic [31:0] write_data,
  input  logic [31:0] alu_result,
  input  logic [4:0]  rd,
  input  logic        reg_write,
  output logic        wb_valid,
  output logic [31:0] wb_value,
  output logic [4:0]  wb_rd,
  output logic        wb_reg_write,
  output logic [31:0] read_data,
  output logic        misalign,
  output logic        clear_busy
);

  localparam int DEPTH = 1 << DEPTH_LOG2;
  localparam logic [DEPTH_LOG2-1:0] PTR_ONE = 1;

  typedef enum logic {S_CLEAR, S_RUN} state_t;

  state_t                state_q;
  logic [DEPTH_LOG2-1:0] clear_ptr_q;
  logic [31:0]           mem_q [DEPTH];

  logic                  wb_valid_q, wb_reg_write_q, misalign_q;
  logic [31:0]           wb_value_q, read_data_q;
  logic [4:0]            wb_rd_q;

  logic                  accept, mis, do_store;
  logic [DEPTH_LOG2-1:0] idx;
  logic [31:0]           rword, wrep, read_data_d, wb_value_d;
  logic [7:0]            lane_b;
  logic [15:0]           lane_h;
  logic [3:0]            be;
  logic                  unused_addr;

  // Upper address bits are deliberately ignored so accesses wrap.
  assign unused_addr = ^addr[31:DEPTH_LOG2+2];

  assign accept   = in_valid && (state_q == S_RUN);
  assign idx      = addr[DEPTH_LOG2+1:2];
  assign mis      = (mem_read || mem_write) &&
                    ((size == 2'b01 && addr[0]) || (size[1] && addr[1:0] != 2'b00));
  assign do_store = accept && mem_write && !mis;
  assign rword    = mem_q[idx];

  always_comb begin
    lane_b = rword[7:0];
    case (addr[1:0])
      2'd1:    lane_b = rword[15:8];
      2'd2:    lane_b = rword[23:16];
      2'd3:    lane_b = rword[31:24];
      default: lane_b = rword[7:0];
    endcase
    lane_h = addr[1] ? rword[31:16] : rword[15:0];

    read_data_d = '0;
    if (mem_read && !mem_write && !mis) begin
      case (size)
        2'b00:   read_data_d = load_unsigned ? {24'b0, lane_b} : {{24{lane_b[7]}}, lane_b};
        2'b01:   read_data_d = load_unsigned ? {16'b0, lane_h} : {{16{lane_h[15]}}, lane_h};
        default: read_data_d = rword;
      endcase
    end
    wb_value_d = mem_to_reg ? read_data_d : alu_result;
  end

  // Replicate store data across lanes; the byte enables pick which lanes land.
  always_comb begin
    case (size)
      2'b00: begin
        be   = 4'b0001 << addr[1:0];
        wrep = {4{write_data[7:0]}};
      end
      2'b01: begin
        be   = addr[1] ? 4'b1100 : 4'b0011;
        wrep = {2{write_data[15:0]}};
      end
      default: begin
        be   = 4'b1111;
        wrep = write_data;
      end
    endcase
  end

  // RAM has no reset; reset only gates the sweep so the contents stay untouched.
  always_ff @(posedge clk) begin
    if (!reset && state_q == S_CLEAR) begin
      mem_q[clear_ptr_q] <= '0;
    end else if (!reset && do_store) begin
      for (int b = 0; b < 4; b++) begin
        if (be[b]) mem_q[idx][8*b +: 8] <= wrep[8*b +: 8];
      end
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q        <= S_CLEAR;
      clear_ptr_q    <= '0;
      wb_valid_q     <= 1'b0;
      wb_reg_write_q <= 1'b0;
      misalign_q     <= 1'b0;
      wb_value_q     <= '0;
      read_data_q    <= '0;
      wb_rd_q        <= '0;
    end else begin
      case (state_q)
        S_CLEAR: begin
          clear_ptr_q <= clear_ptr_q + PTR_ONE;
          if (clear_ptr_q == {DEPTH_LOG2{1'b1}}) state_q <= S_RUN;
        end
        default: state_q <= S_RUN;
      endcase

      wb_valid_q     <= accept;
      wb_reg_write_q <= accept && reg_write && !mis;
      misalign_q     <= accept && mis;
      if (accept) begin
        read_data_q <= read_data_d;
        wb_value_q  <= wb_value_d;
        wb_rd_q     <= rd;
      end
    end
  end

  assign in_ready     = (state_q == S_RUN);
  assign clear_busy   = (state_q == S_CLEAR);
  assign wb_valid     = wb_valid_q;
  assign wb_reg_write = wb_reg_write_q;
  assign misalign     = misalign_q;
  assign wb_value     = wb_value_q;
  assign read_data    = read_data_q;
  assign wb_rd        = wb_rd_q;

endmodule
